// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - sequencer bus between alu_seq_ctrl, instruction memory, register file and alu
interface alu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  stall;
    logic [31:0]           instr;
    logic                  EQ;
    logic [ADDR_WIDTH-1:0] PC;
    logic                  ALUctrl;
    logic                  ALUsrc;
    logic [DATA_WIDTH-1:0] ImmOp;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  RegWrite;
    logic                  illegal;

    modport master (
        input  stall, instr, EQ,
        output PC, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, RegWrite, illegal
    );

    modport slave (
        output stall, instr, EQ,
        input  PC, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, RegWrite, illegal
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle fetch/decode/execute sequencer for the addi/bne subset
module alu_seq_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [31:0]           imm_q, imm_d;
    logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                  is_bne_q, is_bne_d;
    logic                  illegal_q, illegal_d;
    logic                  alu_ctrl, alu_src, reg_write;

    logic [ADDR_WIDTH-1:0] target;
    logic                  dec_addi, dec_bne;

    assign dec_addi = (ir_q[6:0] == 7'b0010011) && (ir_q[14:12] == 3'b000);
    assign dec_bne  = (ir_q[6:0] == 7'b1100011) && (ir_q[14:12] == 3'b001);
    // Immediate is truncated/sign-extended to the PC width so backward branches wrap correctly
    assign target   = pc_q + ADDR_WIDTH'(signed'(imm_q));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        is_bne_d  = is_bne_q;
        illegal_d = illegal_q;
        alu_ctrl  = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;

        case (state_q)
            FETCH: begin
                if (!bus.stall) begin
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!bus.stall) begin
                    rs1_d = ir_q[19:15];
                    rs2_d = ir_q[24:20];
                    rd_d  = ir_q[11:7];
                    if (dec_addi) begin
                        imm_d    = {{20{ir_q[31]}}, ir_q[31:20]};
                        is_bne_d = 1'b0;
                        state_d  = EXECUTE;
                    end else if (dec_bne) begin
                        imm_d    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                        is_bne_d = 1'b1;
                        state_d  = EXECUTE;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                end
            end
            EXECUTE: begin
                alu_ctrl = is_bne_q;
                alu_src  = !is_bne_q;
                if (!bus.stall) begin
                    if (!is_bne_q) begin
                        state_d = WRITEBACK;
                    end else if (bus.EQ) begin
                        pc_d    = pc_q + ADDR_WIDTH'(4);
                        state_d = FETCH;
                    end else if (target[1:0] != 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                alu_src = 1'b1;
                // The pulse lands in the first unstalled cycle, which is also the one that leaves this state
                if (!bus.stall) begin
                    reg_write = (rd_q != 5'd0);
                    pc_d      = pc_q + ADDR_WIDTH'(4);
                    state_d   = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            is_bne_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            is_bne_q  <= is_bne_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.ALUctrl  = alu_ctrl;
    assign bus.ALUsrc   = alu_src;
    assign bus.ImmOp    = DATA_WIDTH'(signed'(imm_q));
    assign bus.rs1      = rs1_q;
    assign bus.rs2      = rs2_q;
    assign bus.rd       = rd_q;
    assign bus.RegWrite = reg_write;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed bench for alu_seq_ctrl with a RegWrite scoreboard
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ba ();
    alu_seq_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bb ();

    logic [31:0] imem_a [16];
    logic [31:0] imem_b [16];

    assign ba.instr = imem_a[ba.PC[5:2]];
    assign bb.instr = imem_b[bb.PC[5:2]];

    alu_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ba)
    );

    alu_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bb)
    );

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_rd_q [$];

    function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
        logic [11:0] i;
        i = 12'(imm);
        return {i, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_bne(int rs1, int rs2, int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b001, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every RegWrite pulse must match the oldest expected write address
    always @(negedge clk) begin
        #3;
        if (rst_n === 1'b1 && ba.RegWrite === 1'b1) begin
            checks++;
            assert (exp_rd_q.size() != 0) else begin
                errors++;
                $error("FAIL regwrite_unexpected: observed pulse rd=%0d expected no pulse", ba.rd);
            end
            if (exp_rd_q.size() != 0) begin
                logic [4:0] e;
                e = exp_rd_q.pop_front();
                checks++;
                assert (ba.rd === e) else begin
                    errors++;
                    $error("FAIL regwrite_rd: observed %0d expected %0d", ba.rd, e);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            imem_a[i] = 32'h0;
            imem_b[i] = 32'h0;
        end
        imem_a[0]  = 32'h0070_0293;
        imem_a[1]  = enc_bne(1, 2, 12);
        imem_a[2]  = enc_addi(0, 0, 1);
        imem_a[3]  = enc_addi(6, 1, -1);
        imem_a[4]  = enc_bne(1, 2, -8);
        imem_a[5]  = enc_bne(1, 2, 2);
        imem_b[15] = enc_addi(7, 0, 1);
        imem_b[0]  = enc_bne(0, 0, -4);

        rst_n = 1'b0; rst_nb = 1'b0;
        ba.stall = 1'b0; ba.EQ = 1'b0;
        bb.stall = 1'b0; bb.EQ = 1'b0;
        tick(2);
        chk("reset_pc", ba.PC, 32'h0);
        chk("reset_regwrite", 32'(ba.RegWrite), 32'h0);
        chk("reset_illegal", 32'(ba.illegal), 32'h0);
        chk("reset_aluctrl", 32'(ba.ALUctrl), 32'h0);
        chk("reset_alusrc", 32'(ba.ALUsrc), 32'h0);
        chk("reset_immop", ba.ImmOp, 32'h0);
        chk("reset_rd", 32'(ba.rd), 32'h0);
        chk("reset_pc_b", bb.PC, 32'hFFFF_FFFC);

        // addi x5,x0,7 at PC=0
        exp_rd_q.push_back(5'd5);
        rst_n = 1'b1; rst_nb = 1'b1;
        tick(1);
        chk("addi_decode_pc", ba.PC, 32'h0);
        tick(1);
        chk("addi_rd", 32'(ba.rd), 32'd5);
        chk("addi_rs1", 32'(ba.rs1), 32'd0);
        chk("addi_imm", ba.ImmOp, 32'd7);
        chk("addi_ex_aluctrl", 32'(ba.ALUctrl), 32'h0);
        chk("addi_ex_alusrc", 32'(ba.ALUsrc), 32'h1);
        chk("addi_ex_regwrite", 32'(ba.RegWrite), 32'h0);
        tick(1);
        chk("addi_wb_alusrc", 32'(ba.ALUsrc), 32'h1);
        chk("addi_wb_pc", ba.PC, 32'h0);
        tick(1);
        chk("addi_pc_next", ba.PC, 32'h4);
        chk("addi_fetch_alusrc", 32'(ba.ALUsrc), 32'h0);
        chk("wrap_addi_pc_b", bb.PC, 32'h0);

        // bne x1,x2,+12 at 0x04, taken
        tick(2);
        chk("bne_ex_aluctrl", 32'(ba.ALUctrl), 32'h1);
        chk("bne_ex_alusrc", 32'(ba.ALUsrc), 32'h0);
        chk("bne_imm_fwd", ba.ImmOp, 32'd12);
        chk("bne_rs1", 32'(ba.rs1), 32'd1);
        chk("bne_rs2", 32'(ba.rs2), 32'd2);
        tick(1);
        chk("bne_fwd_pc", ba.PC, 32'h10);
        chk("wrap_bne_pc_b", bb.PC, 32'hFFFF_FFFC);
        rst_nb = 1'b0;

        // bne x1,x2,-8 at 0x10, taken backwards
        tick(2);
        chk("bne_imm_back", ba.ImmOp, 32'hFFFF_FFF8);
        tick(1);
        chk("bne_back_pc", ba.PC, 32'h08);
        chk("bne_no_regwrite", 32'(ba.RegWrite), 32'h0);

        // addi x0 at 0x08: no pulse expected
        tick(4);
        chk("addi_x0_pc", ba.PC, 32'h0C);

        // addi x6,x1,-1 at 0x0C with WRITEBACK stalled 5 cycles
        exp_rd_q.push_back(5'd6);
        tick(2);
        chk("addi_neg_imm", ba.ImmOp, 32'hFFFF_FFFF);
        tick(1);
        ba.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_pc", ba.PC, 32'h0C);
            chk("stall_alusrc", 32'(ba.ALUsrc), 32'h1);
            chk("stall_regwrite", 32'(ba.RegWrite), 32'h0);
        end
        ba.stall = 1'b0;
        tick(1);
        chk("stall_release_pc", ba.PC, 32'h10);

        // bne at 0x10, EQ=1: falls through
        ba.EQ = 1'b1;
        tick(3);
        chk("bne_eq_pc", ba.PC, 32'h14);
        ba.EQ = 1'b0;

        // bne +2 at 0x14: misaligned target halts
        tick(3);
        chk("misalign_illegal", 32'(ba.illegal), 32'h1);
        chk("misalign_pc", ba.PC, 32'h14);
        for (int i = 0; i < 4; i++) begin
            ba.stall = (i % 2 == 0);
            tick(1);
            chk("halt_pc", ba.PC, 32'h14);
            chk("halt_illegal", 32'(ba.illegal), 32'h1);
            chk("halt_aluctrl", 32'(ba.ALUctrl), 32'h0);
        end
        ba.stall = 1'b0;

        // reset out of HALT, then asynchronous reset mid-EXECUTE of addi
        rst_n = 1'b0;
        tick(1);
        chk("halt_reset_illegal", 32'(ba.illegal), 32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("midex_alusrc", 32'(ba.ALUsrc), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc", ba.PC, 32'h0);
        chk("async_regwrite", 32'(ba.RegWrite), 32'h0);
        chk("async_alusrc", 32'(ba.ALUsrc), 32'h0);
        chk("async_rd", 32'(ba.rd), 32'h0);
        chk("async_illegal", 32'(ba.illegal), 32'h0);

        // add (R-type) is illegal
        imem_a[0] = 32'h0000_0033;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("illegal_before_decode", 32'(ba.illegal), 32'h0);
        tick(1);
        chk("illegal_set", 32'(ba.illegal), 32'h1);
        chk("illegal_pc", ba.PC, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ba.stall = (i % 2 == 1);
            tick(1);
            chk("illegal_hold", 32'(ba.illegal), 32'h1);
            chk("illegal_hold_pc", ba.PC, 32'h0);
        end
        ba.stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("illegal_cleared", 32'(ba.illegal), 32'h0);

        tick(1);
        chk("scoreboard_empty", 32'(exp_rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
